// File: rtl/puf_pkg.sv
// Package puf_pkg
//  Shared types and defaults for the CRO PUF measurement path.
//  - PUF_CHAL_W / PUF_CNT_W : default challenge and count widths, shared with
//    the CRO and edge-counter blocks so all three agree on the bus shape.
//  - seq_state_t            : challenge sequencer state encoding.
//  - max3                   : helper used to size the shared down-counter.
package puf_pkg;

   localparam int PUF_CHAL_W = 6;
   localparam int PUF_CNT_W  = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      REQ    = 3'd2,
      WAIT   = 3'd3,
      CMP    = 3'd4,
      GAP    = 3'd5,
      DONE   = 3'd6
   } seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/puf_challenge_seq_if.sv
// Interface puf_challenge_seq_if
//  Bus between the challenge sequencer (master) and the CRO + edge counter
//  (slave).
//  Handshake: the master raises meas_start for exactly one cycle to open a
//  counting window for the current challenge; the slave later raises
//  meas_done for exactly one cycle with meas_count valid in that same cycle.
//  There is no back-pressure; meas_done is only honoured while the master is
//  waiting for it and is ignored at any other time.
//  Signals:
//   challenge  master->slave  CHAL_W  challenge to the CRO, {sel,bx}
//   ro_en      master->slave  1       CRO enable
//   meas_start master->slave  1       one-cycle window request
//   meas_done  slave->master  1       one-cycle result strobe
//   meas_count slave->master  CNT_W   RO edge count for the window
interface puf_challenge_seq_if #(
   parameter int CHAL_W = puf_pkg::PUF_CHAL_W,
   parameter int CNT_W  = puf_pkg::PUF_CNT_W
);
   logic [CHAL_W-1:0] challenge;
   logic              ro_en;
   logic              meas_start;
   logic              meas_done;
   logic [CNT_W-1:0]  meas_count;

   modport master (
      output challenge, ro_en, meas_start,
      input  meas_done, meas_count
   );

   modport slave (
      input  challenge, ro_en, meas_start,
      output meas_done, meas_count
   );
endinterface

// File: rtl/puf_seq_timer.sv
// Module puf_seq_timer
//  Loadable down-counter shared by the SETTLE, GAP and measurement-timeout
//  phases of the sequencer. Counts down while en=1 and saturates at zero.
//  Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      load load_val this cycle (has priority over en)
//   load_val  value to load
//   en        decrement this cycle
//   expired   count is zero
module puf_seq_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/puf_challenge_seq.sv
// Module puf_challenge_seq
//  Initiator side of the CRO measurement path. Sweeps all 2**CHAL_W
//  challenges, requests one edge count per challenge and compares adjacent
//  pairs into the PUF response: bit k = cnt(2k) > cnt(2k+1), unsigned, tie 0.
//  Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        begin a sweep (honoured in IDLE and DONE only)
//   abort        synchronous abort back to IDLE, response kept
//   meas         master side of the CRO/counter bus
//   response     PUF response bits
//   busy         sweep in progress (not IDLE/DONE)
//   done         sweep finished (or timed out); response stable
//   timeout_err  a measurement timed out; cleared by the next accepted start
//   state_dbg    current sequencer state
module puf_challenge_seq
   import puf_pkg::*;
#(
   parameter int CHAL_W      = PUF_CHAL_W,
   parameter int CNT_W       = PUF_CNT_W,
   parameter int SETTLE_CYC  = 16,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 2**26
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   puf_challenge_seq_if.master        meas,
   output logic [2**(CHAL_W-1)-1:0]   response,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout_err,
   output seq_state_t                 state_dbg
);

   localparam int TW = $clog2(max3(SETTLE_CYC, GAP_CYC, TIMEOUT_CYC)) + 1;
   // Timer is loaded with N-1 so that the phase lasts exactly N cycles.
   localparam logic [TW-1:0] SETTLE_LD  = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] GAP_LD     = TW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);

   seq_state_t        state_q, state_n;
   logic [CHAL_W-1:0] idx_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  ref_cnt_q;

   logic          tmr_load, tmr_en, tmr_expired;
   logic [TW-1:0] tmr_ld_val;
   logic          clr_sweep, latch_cnt, do_cmp, idx_inc, set_to;

   puf_seq_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_ld_val),
      .en       (tmr_en),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_n;
   end

   always_comb begin
      state_n    = state_q;
      tmr_load   = 1'b0;
      tmr_ld_val = '0;
      tmr_en     = 1'b0;
      clr_sweep  = 1'b0;
      latch_cnt  = 1'b0;
      do_cmp     = 1'b0;
      idx_inc    = 1'b0;
      set_to     = 1'b0;
      if (abort) begin
         state_n = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_n    = SETTLE;
                  clr_sweep  = 1'b1;
                  tmr_load   = 1'b1;
                  tmr_ld_val = SETTLE_LD;
               end
            end
            SETTLE: begin
               if (tmr_expired) state_n = REQ;
               else             tmr_en  = 1'b1;
            end
            REQ: begin
               state_n    = WAIT;
               tmr_load   = 1'b1;
               tmr_ld_val = TIMEOUT_LD;
            end
            WAIT: begin
               // A result arriving on the expiry cycle still counts.
               if (meas.meas_done) begin
                  state_n   = CMP;
                  latch_cnt = 1'b1;
               end else if (tmr_expired) begin
                  state_n = DONE;
                  set_to  = 1'b1;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            CMP: begin
               state_n    = GAP;
               do_cmp     = 1'b1;
               tmr_load   = 1'b1;
               tmr_ld_val = GAP_LD;
            end
            GAP: begin
               if (!tmr_expired) begin
                  tmr_en = 1'b1;
               end else if (idx_q == '1) begin
                  state_n = DONE;
               end else begin
                  state_n    = SETTLE;
                  idx_inc    = 1'b1;
                  tmr_load   = 1'b1;
                  tmr_ld_val = SETTLE_LD;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Datapath and registered outputs. Outputs are decoded from the next
   // state so they change on the same edge as the state itself and stay
   // glitch-free toward the CRO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q           <= '0;
         count_q         <= '0;
         ref_cnt_q       <= '0;
         response        <= '0;
         timeout_err     <= 1'b0;
         meas.ro_en      <= 1'b0;
         meas.meas_start <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         if (clr_sweep) begin
            idx_q       <= '0;
            response    <= '0;
            timeout_err <= 1'b0;
         end
         if (idx_inc)   idx_q       <= idx_q + 1'b1;
         if (latch_cnt) count_q     <= meas.meas_count;
         if (set_to)    timeout_err <= 1'b1;
         if (do_cmp) begin
            if (!idx_q[0]) ref_cnt_q <= count_q;
            else           response[idx_q[CHAL_W-1:1]] <= (ref_cnt_q > count_q);
         end
         meas.ro_en      <= (state_n == SETTLE) || (state_n == REQ) ||
                            (state_n == WAIT)   || (state_n == CMP);
         meas.meas_start <= (state_n == REQ);
         busy            <= (state_n != IDLE) && (state_n != DONE);
         done            <= (state_n == DONE);
      end
   end

   // idx only moves while ro_en is low, so challenge is stable in a window.
   assign meas.challenge = idx_q;
   assign state_dbg      = state_q;

endmodule
